hls_deadlock_report_collector: RTL and testbench

- Receiving end of the per-instance HLS deadlock monitors' registered `block` outputs; one `mon_block` bit per monitor.
- Filters transient blocking and confirms a deadlock only after persistent blocking.
- Delivers one report beat per confirmed deadlock on a valid/ready interface toward the debug/status logic, and raises a sticky interrupt.
- Sits at design top level beside the monitors; single clock domain.

---
 rtl/hls_deadlock_report_collector.sv | 120 ++++++++++++
 tb/tb_hls_deadlock_report_collector.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/hls_deadlock_report_collector.sv
// rtl/hls_deadlock_report_collector.sv - confirms persistent HLS monitor blocking and reports it over valid/ready
module hls_deadlock_report_collector #(
    parameter int NUM_MON   = 4,
    parameter int CNT_W     = 16,
    parameter int THRESHOLD = 1024,
    parameter int TRANS_W   = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_MON-1:0] mon_block,
    input  logic               clear,
    output logic               report_valid,
    input  logic               report_ready,
    output logic [NUM_MON-1:0] report_mask,
    output logic [CNT_W-1:0]   report_cycles,
    output logic               deadlock_irq,
    output logic [TRANS_W-1:0] transient_cnt,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        REPORT  = 2'd2,
        LATCHED = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]   THR_VAL   = CNT_W'(THRESHOLD);
    localparam logic [CNT_W-1:0]   THR_LAST  = CNT_W'(THRESHOLD - 1);
    localparam logic [TRANS_W-1:0] TRANS_MAX = {TRANS_W{1'b1}};

    state_t             state;
    logic [CNT_W-1:0]   counter;
    logic [NUM_MON-1:0] mask;
    logic               any_blk;

    // Any monitor reporting a blocked instance this cycle
    always_comb begin
        any_blk = |mon_block;
    end

    // Episode tracking FSM; every output is registered alongside the state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            counter       <= '0;
            mask          <= '0;
            report_valid  <= 1'b0;
            report_mask   <= '0;
            report_cycles <= '0;
            deadlock_irq  <= 1'b0;
            transient_cnt <= '0;
            busy          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear) begin
                        counter <= '0;
                        mask    <= '0;
                    end else if (any_blk) begin
                        state   <= COUNT;
                        busy    <= 1'b1;
                        counter <= CNT_W'(1);
                        mask    <= mon_block;
                    end
                end
                COUNT: begin
                    if (clear) begin
                        // Re-arm wins over both continuation and a threshold crossing
                        state   <= IDLE;
                        busy    <= 1'b0;
                        counter <= '0;
                        mask    <= '0;
                    end else if (any_blk) begin
                        mask <= mask | mon_block;
                        if (counter == THR_LAST) begin
                            state         <= REPORT;
                            report_cycles <= THR_VAL;
                            report_mask   <= mask | mon_block;
                            report_valid  <= 1'b1;
                            deadlock_irq  <= 1'b1;
                        end else begin
                            counter <= counter + CNT_W'(1);
                        end
                    end else begin
                        // Episode ended early: count it as transient, saturating
                        state   <= IDLE;
                        busy    <= 1'b0;
                        counter <= '0;
                        mask    <= '0;
                        if (transient_cnt != TRANS_MAX) begin
                            transient_cnt <= transient_cnt + TRANS_W'(1);
                        end
                    end
                end
                REPORT: begin
                    // Payload frozen until accepted; clear cannot drop it
                    if (report_ready) begin
                        report_valid <= 1'b0;
                        state        <= LATCHED;
                    end
                end
                LATCHED: begin
                    if (clear) begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        counter      <= '0;
                        mask         <= '0;
                        deadlock_irq <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hls_deadlock_report_collector.sv
// tb/tb_hls_deadlock_report_collector.sv - directed self-checking bench for hls_deadlock_report_collector
module tb_hls_deadlock_report_collector;

    logic        clock;
    logic        reset;
    logic [3:0]  mon_block;
    logic        clear;
    logic        report_valid;
    logic        report_ready;
    logic [3:0]  report_mask;
    logic [15:0] report_cycles;
    logic        deadlock_irq;
    logic [7:0]  transient_cnt;
    logic        busy;

    int total = 0;
    int bad   = 0;

    hls_deadlock_report_collector #(
        .NUM_MON  (4),
        .CNT_W    (16),
        .THRESHOLD(8),
        .TRANS_W  (8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .mon_block    (mon_block),
        .clear        (clear),
        .report_valid (report_valid),
        .report_ready (report_ready),
        .report_mask  (report_mask),
        .report_cycles(report_cycles),
        .deadlock_irq (deadlock_irq),
        .transient_cnt(transient_cnt),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic block_n(input logic [3:0] v, input int n);
        mon_block = v;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_clear(input logic [3:0] v);
        mon_block = v;
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        mon_block = '0;
        clear = 1'b0;
        report_ready = 1'b0;
        tick();
        tick();
        check("rst_valid", report_valid, 0);
        check("rst_mask", report_mask, 0);
        check("rst_cycles", report_cycles, 0);
        check("rst_irq", deadlock_irq, 0);
        check("rst_trans", transient_cnt, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;

        // Basic confirmation after 8 blocked edges
        block_n(4'b0010, 7);
        check("b_valid_e7", report_valid, 0);
        check("b_busy_e7", busy, 1);
        block_n(4'b0010, 1);
        check("b_valid_e8", report_valid, 1);
        check("b_mask", report_mask, 4'b0010);
        check("b_cycles", report_cycles, 8);
        check("b_irq", deadlock_irq, 1);
        report_ready = 1'b1;
        mon_block = 4'b0000;
        tick();
        report_ready = 1'b0;
        check("b_hs_valid", report_valid, 0);
        check("b_latched_busy", busy, 1);
        check("b_latched_irq", deadlock_irq, 1);
        pulse_clear(4'b0000);
        check("b_clr_irq", deadlock_irq, 0);
        check("b_clr_busy", busy, 0);
        check("b_clr_mask_kept", report_mask, 4'b0010);
        check("b_clr_cycles_kept", report_cycles, 8);

        // Transient episode of 7 edges
        block_n(4'b0001, 7);
        block_n(4'b0000, 1);
        check("t_valid", report_valid, 0);
        check("t_cnt1", transient_cnt, 1);
        check("t_busy", busy, 0);

        // Clear mid-count restarts the count and does not touch transient_cnt
        block_n(4'b0100, 5);
        pulse_clear(4'b0100);
        check("c_busy", busy, 0);
        check("c_trans", transient_cnt, 1);
        block_n(4'b0100, 7);
        check("c_valid_e7", report_valid, 0);
        block_n(4'b0100, 1);
        check("c_valid_e8", report_valid, 1);
        check("c_mask", report_mask, 4'b0100);
        check("c_trans_after", transient_cnt, 1);

        // Clear during REPORT is ignored
        pulse_clear(4'b0000);
        check("r_clr_valid", report_valid, 1);
        check("r_clr_irq", deadlock_irq, 1);
        report_ready = 1'b1;
        tick();
        report_ready = 1'b0;
        check("r_hs_valid", report_valid, 0);
        pulse_clear(4'b0000);
        check("r_clr_busy", busy, 0);

        // Mask accumulation across alternating monitors, then back-pressure
        for (int i = 0; i < 8; i++) block_n((i % 2 == 0) ? 4'b0001 : 4'b1000, 1);
        check("m_valid", report_valid, 1);
        check("m_mask", report_mask, 4'b1001);
        block_n(4'b0110, 1);
        block_n(4'b0000, 1);
        block_n(4'b1111, 1);
        block_n(4'b0100, 1);
        block_n(4'b0010, 1);
        check("m_hold_valid", report_valid, 1);
        check("m_hold_mask", report_mask, 4'b1001);
        check("m_hold_cycles", report_cycles, 8);
        report_ready = 1'b1;
        tick();
        report_ready = 1'b0;
        check("m_hs_valid", report_valid, 0);
        block_n(4'b1111, 2);
        check("m_latched_busy", busy, 1);
        check("m_latched_valid", report_valid, 0);
        check("m_latched_mask", report_mask, 4'b1001);
        pulse_clear(4'b0000);
        check("m_clr_busy", busy, 0);
        check("m_clr_irq", deadlock_irq, 0);

        // Saturation of transient_cnt: 299 further episodes
        for (int k = 0; k < 299; k++) begin
            block_n(4'b0001, 7);
            block_n(4'b0000, 1);
        end
        check("s_sat", transient_cnt, 255);
        check("s_valid", report_valid, 0);

        // Asynchronous reset while a report is pending
        block_n(4'b0010, 8);
        check("a_valid_pre", report_valid, 1);
        #3;
        reset = 1'b1;
        #1;
        check("a_valid", report_valid, 0);
        check("a_irq", deadlock_irq, 0);
        check("a_busy", busy, 0);
        check("a_trans", transient_cnt, 0);
        check("a_mask", report_mask, 0);
        mon_block = 4'b0000;
        tick();
        reset = 1'b0;
        block_n(4'b1000, 7);
        check("a2_valid_e7", report_valid, 0);
        block_n(4'b1000, 1);
        check("a2_valid_e8", report_valid, 1);
        check("a2_mask", report_mask, 4'b1000);
        check("a2_cycles", report_cycles, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
